// File: rtl/int_bus_mailbox.sv
// Register-mapped byte mailbox on the uart2bus internal bus: a host-to-local
// down FIFO, a local-to-host up FIFO, status/level/control registers and an irq.
module int_bus_mailbox #(
  parameter int         FIFO_AW   = 3,
  parameter logic [7:0] ADDR_BASE = 8'h10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] int_address,
  input  logic [7:0] int_wr_data,
  input  logic       int_write,
  input  logic       int_read,
  output logic [7:0] int_rd_data,
  output logic [7:0] dn_data,
  output logic       dn_valid,
  input  logic       dn_ready,
  input  logic [7:0] up_data,
  input  logic       up_valid,
  output logic       up_ready,
  output logic       irq
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  // Handshake: a byte moves on a rising edge where valid && ready are both
  // high; valid never waits on ready, and ready never depends on valid.

  logic [7:0]       dn_mem [DEPTH];
  logic [FIFO_AW-1:0] dn_wp, dn_rp;
  logic [FIFO_AW:0]   dn_cnt, dn_cnt_nxt;
  logic [7:0]       up_mem [DEPTH];
  logic [FIFO_AW-1:0] up_wp, up_rp;
  logic [FIFO_AW:0]   up_cnt, up_cnt_nxt;

  logic       dn_ovf, up_udf, irq_en, irq_en_nxt;
  logic [7:0] off;
  logic       hit;
  logic       data_wr, ctrl_wr, data_rd;
  logic       dn_full, dn_empty, up_full, up_empty;
  logic       dn_push, dn_pop, dn_flush, dn_ovf_evt;
  logic       up_push, up_pop, up_flush, up_udf_evt;
  logic       clr_err;
  logic [7:0] status, level, control, rd_nxt;

  // Offset decode wraps modulo 256, so a base near the top of the map still works.
  assign off     = int_address - ADDR_BASE;
  assign hit     = (off[7:2] == 6'd0);
  assign data_wr = int_write && hit && (off[1:0] == 2'd0);
  assign ctrl_wr = int_write && hit && (off[1:0] == 2'd2);
  assign data_rd = int_read  && hit && (off[1:0] == 2'd0);

  assign dn_full  = (dn_cnt == FULL_CNT);
  assign dn_empty = (dn_cnt == '0);
  assign up_full  = (up_cnt == FULL_CNT);
  assign up_empty = (up_cnt == '0);

  assign dn_flush = ctrl_wr && int_wr_data[0];
  assign up_flush = ctrl_wr && int_wr_data[1];
  assign clr_err  = ctrl_wr && int_wr_data[2];

  assign dn_valid   = !dn_empty;
  assign dn_data    = dn_mem[dn_rp];
  assign dn_pop     = dn_valid && dn_ready;
  assign dn_push    = data_wr && (!dn_full || dn_pop);
  assign dn_ovf_evt = data_wr && dn_full && !dn_pop;

  // A DATA read popping this cycle frees a slot, so a full up FIFO still
  // accepts the producer's byte in the same cycle.
  assign up_pop     = data_rd && !up_empty;
  assign up_udf_evt = data_rd && up_empty;
  assign up_ready   = !up_full || up_pop;
  assign up_push    = up_valid && up_ready;

  assign irq_en_nxt = ctrl_wr ? int_wr_data[3] : irq_en;

  always_comb begin
    dn_cnt_nxt = dn_cnt;
    if (dn_flush)
      dn_cnt_nxt = '0;
    else if (dn_push && !dn_pop)
      dn_cnt_nxt = dn_cnt + 1'b1;
    else if (dn_pop && !dn_push)
      dn_cnt_nxt = dn_cnt - 1'b1;
  end

  always_comb begin
    up_cnt_nxt = up_cnt;
    if (up_flush)
      up_cnt_nxt = '0;
    else if (up_push && !up_pop)
      up_cnt_nxt = up_cnt + 1'b1;
    else if (up_pop && !up_push)
      up_cnt_nxt = up_cnt - 1'b1;
  end

  assign status  = {2'b00, up_udf, dn_ovf, up_empty, up_full, dn_empty, dn_full};
  assign level   = {4'(up_cnt), 4'(dn_cnt)};
  assign control = {4'h0, irq_en, 3'b000};

  always_comb begin
    rd_nxt = 8'h00;
    if (hit) begin
      case (off[1:0])
        2'd0:    rd_nxt = up_pop ? up_mem[up_rp] : 8'h00;
        2'd1:    rd_nxt = status;
        2'd2:    rd_nxt = control;
        default: rd_nxt = level;
      endcase
    end
  end

  // Storage holds no reset: contents are only observable through valid counts.
  always_ff @(posedge clock) begin
    if (dn_push)
      dn_mem[dn_wp] <= int_wr_data;
    if (up_push)
      up_mem[up_wp] <= up_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dn_wp  <= '0;
      dn_rp  <= '0;
      dn_cnt <= '0;
    end else begin
      dn_cnt <= dn_cnt_nxt;
      if (dn_flush) begin
        dn_wp <= '0;
        dn_rp <= '0;
      end else begin
        if (dn_push)
          dn_wp <= dn_wp + 1'b1;
        if (dn_pop)
          dn_rp <= dn_rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      up_wp  <= '0;
      up_rp  <= '0;
      up_cnt <= '0;
    end else begin
      up_cnt <= up_cnt_nxt;
      if (up_flush) begin
        up_wp <= '0;
        up_rp <= '0;
      end else begin
        if (up_push)
          up_wp <= up_wp + 1'b1;
        if (up_pop)
          up_rp <= up_rp + 1'b1;
      end
    end
  end

  // A new error event outranks clr_err arriving in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dn_ovf      <= 1'b0;
      up_udf      <= 1'b0;
      irq_en      <= 1'b0;
      irq         <= 1'b0;
      int_rd_data <= 8'h00;
    end else begin
      if (dn_ovf_evt)
        dn_ovf <= 1'b1;
      else if (clr_err)
        dn_ovf <= 1'b0;
      if (up_udf_evt)
        up_udf <= 1'b1;
      else if (clr_err)
        up_udf <= 1'b0;
      irq_en <= irq_en_nxt;
      irq    <= irq_en_nxt && (up_cnt_nxt != '0);
      if (int_read)
        int_rd_data <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_int_bus_mailbox.sv
// Directed bench for int_bus_mailbox: queue-based mailbox model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_int_bus_mailbox;

  localparam int         DEPTH = 8;
  localparam logic [7:0] BASE  = 8'h10;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] int_address = 8'h00;
  logic [7:0] int_wr_data = 8'h00;
  logic       int_write = 1'b0;
  logic       int_read = 1'b0;
  logic [7:0] int_rd_data;
  logic [7:0] dn_data;
  logic       dn_valid;
  logic       dn_ready = 1'b0;
  logic [7:0] up_data = 8'h00;
  logic       up_valid = 1'b0;
  logic       up_ready;
  logic       irq;

  int checks = 0;
  int errors = 0;

  int_bus_mailbox #(.FIFO_AW(3), .ADDR_BASE(BASE)) dut (
    .clock(clock), .reset(reset),
    .int_address(int_address), .int_wr_data(int_wr_data),
    .int_write(int_write), .int_read(int_read), .int_rd_data(int_rd_data),
    .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- model: mailbox as two queues plus flags ----------------
  logic [7:0] dn_q[$];
  logic [7:0] up_q[$];
  logic       m_ovf = 1'b0, m_udf = 1'b0, m_irq_en = 1'b0;
  logic [7:0] m_rd = 8'h00;
  logic [7:0] m_off;
  logic       m_hit, m_ovf_evt, m_udf_evt;
  int         n_dn, n_up;

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      dn_q.delete();
      up_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_irq_en = 1'b0;
      m_rd = 8'h00;
    end else begin
      m_off = int_address - BASE;
      m_hit = (m_off < 8'd4);
      n_dn = dn_q.size();
      n_up = up_q.size();
      m_ovf_evt = 1'b0;
      m_udf_evt = 1'b0;
      if (int_read) begin
        if (!m_hit) m_rd = 8'h00;
        else if (m_off == 8'd0) m_rd = (n_up > 0) ? up_q[0] : 8'h00;
        else if (m_off == 8'd1)
          m_rd = {2'b00, m_udf, m_ovf, n_up == 0, n_up == DEPTH, n_dn == 0, n_dn == DEPTH};
        else if (m_off == 8'd2) m_rd = {4'h0, m_irq_en, 3'b000};
        else m_rd = {n_up[3:0], n_dn[3:0]};
      end
      if (dn_ready && dn_q.size() > 0) void'(dn_q.pop_front());
      if (int_write && m_hit && m_off == 8'd0) begin
        if (dn_q.size() < DEPTH) dn_q.push_back(int_wr_data);
        else m_ovf_evt = 1'b1;
      end
      if (int_read && m_hit && m_off == 8'd0) begin
        if (up_q.size() > 0) void'(up_q.pop_front());
        else m_udf_evt = 1'b1;
      end
      if (up_valid && up_q.size() < DEPTH) up_q.push_back(up_data);
      if (int_write && m_hit && m_off == 8'd2) begin
        if (int_wr_data[0]) dn_q.delete();
        if (int_wr_data[1]) up_q.delete();
        if (int_wr_data[2]) begin
          m_ovf = 1'b0;
          m_udf = 1'b0;
        end
        m_irq_en = int_wr_data[3];
      end
      if (m_ovf_evt) m_ovf = 1'b1;
      if (m_udf_evt) m_udf = 1'b1;
    end
  end

  // ---------------- per-cycle compare on the falling edge ----------------
  logic exp_up_ready;
  initial forever begin
    @(negedge clock);
    exp_up_ready = (up_q.size() < DEPTH) ||
                   (int_read && int_address == BASE && up_q.size() > 0);
    check("cyc_dn_valid", 8'(dn_valid), 8'(dn_q.size() > 0));
    if (dn_q.size() > 0) check("cyc_dn_data", dn_data, dn_q[0]);
    check("cyc_up_ready", 8'(up_ready), 8'(exp_up_ready));
    check("cyc_irq", 8'(irq), 8'(m_irq_en && up_q.size() > 0));
    check("cyc_rd_data", int_rd_data, m_rd);
  end

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    int_address = a;
    int_wr_data = d;
    int_write = 1'b1;
    cycle();
    int_write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a);
    int_address = a;
    int_read = 1'b1;
    cycle();
    int_read = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    // Reset state
    check("rst_dn_valid", 8'(dn_valid), 8'h00);
    check("rst_up_ready", 8'(up_ready), 8'h01);
    check("rst_irq", 8'(irq), 8'h00);
    check("rst_rd_data", int_rd_data, 8'h00);
    bus_read(BASE + 8'd1);
    check("rst_status", int_rd_data, 8'h0A);
    bus_read(BASE + 8'd3);
    check("rst_level", int_rd_data, 8'h00);

    // Fill down FIFO, overflow, then drain
    for (int i = 0; i < 8; i++) bus_write(BASE, 8'h11 + 8'(i));
    bus_read(BASE + 8'd3);
    check("dn_full_level", int_rd_data, 8'h08);
    bus_read(BASE + 8'd1);
    check("dn_full_status", int_rd_data, 8'h09);
    bus_write(BASE, 8'h19);
    bus_read(BASE + 8'd1);
    check("dn_ovf_status", int_rd_data, 8'h19);
    dn_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("dn_drain_valid", 8'(dn_valid), 8'h01);
      check("dn_drain_data", dn_data, 8'h11 + 8'(i));
      cycle();
    end
    check("dn_drained", 8'(dn_valid), 8'h00);
    dn_ready = 1'b0;

    // Up FIFO with interrupt, then underflow
    bus_write(BASE + 8'd2, 8'h08);
    up_valid = 1'b1;
    up_data = 8'hA5;
    check("irq_before_push", 8'(irq), 8'h00);
    cycle();
    check("irq_after_push", 8'(irq), 8'h01);
    up_data = 8'h5A;
    cycle();
    up_valid = 1'b0;
    bus_read(BASE);
    check("up_rd_a5", int_rd_data, 8'hA5);
    check("irq_one_left", 8'(irq), 8'h01);
    bus_read(BASE);
    check("up_rd_5a", int_rd_data, 8'h5A);
    check("irq_fall", 8'(irq), 8'h00);
    bus_read(BASE);
    check("up_rd_empty", int_rd_data, 8'h00);
    bus_read(BASE + 8'd1);
    check("udf_status", int_rd_data, 8'h3A);

    // Full up FIFO: simultaneous pop and push, with pointer wrap
    up_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up_data = 8'hB0 + 8'(i);
      cycle();
    end
    up_valid = 1'b0;
    #1;
    check("up_full_ready", 8'(up_ready), 8'h00);
    int_address = BASE;
    int_read = 1'b1;
    up_valid = 1'b1;
    up_data = 8'hC3;
    #1;
    check("up_full_pop_ready", 8'(up_ready), 8'h01);
    cycle();
    int_read = 1'b0;
    up_valid = 1'b0;
    check("up_wrap_b0", int_rd_data, 8'hB0);
    bus_read(BASE + 8'd3);
    check("up_count_held", int_rd_data, 8'h80);
    for (int i = 1; i < 8; i++) begin
      bus_read(BASE);
      check("up_wrap_seq", int_rd_data, 8'hB0 + 8'(i));
    end
    bus_read(BASE);
    check("up_last_c3", int_rd_data, 8'hC3);
    bus_read(BASE + 8'd3);
    check("up_empty_level", int_rd_data, 8'h00);

    // Flush concurrent with a consumer pop
    bus_write(BASE, 8'h21);
    bus_write(BASE, 8'h22);
    bus_write(BASE, 8'h23);
    int_address = BASE + 8'd2;
    int_wr_data = 8'h01;
    int_write = 1'b1;
    dn_ready = 1'b1;
    check("flush_head", dn_data, 8'h21);
    cycle();
    int_write = 1'b0;
    dn_ready = 1'b0;
    check("flush_empty", 8'(dn_valid), 8'h00);
    bus_read(BASE + 8'd3);
    check("flush_level", int_rd_data, 8'h00);
    bus_write(BASE + 8'd2, 8'h08);
    bus_read(BASE + 8'd2);
    check("ctrl_readback", int_rd_data, 8'h08);

    // Clear sticky errors, unmapped accesses
    bus_write(BASE + 8'd2, 8'h04);
    bus_read(BASE + 8'd1);
    check("clr_err_status", int_rd_data, 8'h0A);
    bus_read(8'h20);
    check("unmapped_rd", int_rd_data, 8'h00);
    bus_write(8'h20, 8'h55);
    bus_write(8'h0F, 8'h33);
    bus_read(BASE + 8'd3);
    check("unmapped_wr_level", int_rd_data, 8'h00);

    // Asynchronous reset in the middle of a fill
    bus_write(BASE + 8'd2, 8'h08);
    bus_write(BASE, 8'h31);
    bus_write(BASE, 8'h32);
    up_valid = 1'b1;
    up_data = 8'h41;
    cycle();
    up_data = 8'h42;
    cycle();
    up_valid = 1'b0;
    bus_read(BASE + 8'd3);
    check("pre_reset_level", int_rd_data, 8'h22);
    check("pre_reset_irq", 8'(irq), 8'h01);
    int_address = BASE;
    int_wr_data = 8'h33;
    int_write = 1'b1;
    up_valid = 1'b1;
    up_data = 8'h43;
    #2;
    reset = 1'b0;
    #1;
    check("arst_dn_valid", 8'(dn_valid), 8'h00);
    check("arst_up_ready", 8'(up_ready), 8'h01);
    check("arst_irq", 8'(irq), 8'h00);
    check("arst_rd_data", int_rd_data, 8'h00);
    int_write = 1'b0;
    up_valid = 1'b0;
    cycle();
    reset = 1'b1;
    bus_read(BASE + 8'd1);
    check("post_reset_status", int_rd_data, 8'h0A);
    bus_read(BASE + 8'd3);
    check("post_reset_level", int_rd_data, 8'h00);

    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
